// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
//
// Shared definitions for the 7-segment scan driver:
//   - active-low glyph constants for hex digits 0..F, ordered {g,f,e,d,c,b,a}
//   - SEG_OFF, the all-dark segment pattern
//   - glyph_of(): 4-bit value -> active-low segment pattern
//   - cnt_width()/idx_width(): register widths for the slot counter and the
//     digit index, both at least 1 bit wide
// -----------------------------------------------------------------------------
package seg_scan_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  function automatic logic [6:0] glyph_of(input logic [3:0] value);
    logic [6:0] g;
    case (value)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

  // Width needed to count 0..scan_div-1.
  function automatic int cnt_width(input int scan_div);
    int w;
    w = $clog2(scan_div);
    return (w < 1) ? 1 : w;
  endfunction

  // Width needed to index 0..num_digits-1, never narrower than one bit.
  function automatic int idx_width(input int num_digits);
    int w;
    w = $clog2(num_digits);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seg_scan_driver_hex_glyph.sv
// -----------------------------------------------------------------------------
// hex_glyph
//
// Combinational hex-to-7-segment decoder with a blanking override.
// Ports:
//   value_i  [3:0]  hex value to display
//   blank_i         1 = force all segments dark
//   seg_o    [6:0]  active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex_glyph
  import seg_scan_pkg::*;
(
  input  logic [3:0] value_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    if (!blank_i) begin
      seg_o = glyph_of(value_i);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed driver for an N-digit common-anode 7-segment display.
// Each digit owns a slot of SCAN_DIV clocks; the first DEADTIME clocks of a
// slot keep every anode off so the previous digit's pattern cannot ghost onto
// the next one. New frame data is captured into a pending register on load
// and only promoted to the displayed (active) register at the frame boundary,
// so one frame never mixes old and new digits.
//
// Parameters:
//   NUM_DIGITS  digits scanned (2..8)
//   SCAN_DIV    clocks per digit slot (>= DEADTIME+2)
//   DEADTIME    dark clocks at the start of every slot (>= 1)
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   digits       4 bits per digit, digit 0 in [3:0] is the rightmost
//   dp_in        decimal point request per digit, 1 = lit
//   blank        per-digit blank, 1 = digit dark
//   load         capture digits/dp_in/blank into the pending register
//   seg          active-low segments {g,f,e,d,c,b,a}
//   dp           active-low decimal point
//   an           active-low anode enables, at most one low
//   frame_start  one-cycle pulse on the output cycle of slot 0, count 0
//
// Build option:
//   LZ_SUPPRESS_EN  when defined, leading zeros of the active frame are
//                   darkened (digit 0 always shown; a lit decimal point
//                   stops suppression at that digit).
//
// All outputs are registered: they reflect the counter/index state of the
// previous cycle.
// -----------------------------------------------------------------------------
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int DEADTIME   = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = cnt_width(SCAN_DIV);
  localparam int IDX_W = idx_width(NUM_DIGITS);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEADTIME);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;

  logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  // ---------------------------------------------------------------------------
  // Scan timing
  // ---------------------------------------------------------------------------
  logic slot_end;
  logic frame_end;

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / active frame registers
  // The promotion at frame_end uses the pending value from before this edge,
  // so a load landing on the boundary edge waits for the following frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (load) begin
      pend_dig_d   = digits;
      pend_dp_d    = dp_in;
      pend_blank_d = blank;
    end

    act_dig_d   = act_dig_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    if (frame_end) begin
      act_dig_d   = pend_dig_q;
      act_dp_d    = pend_dp_q;
      act_blank_d = pend_blank_q;
    end
  end

  // Unpack the active digits so the current one can be selected by index.
  logic [3:0] act_dig_w [NUM_DIGITS];

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_unpack
    assign act_dig_w[gi] = act_dig_q[gi*4 +: 4];
  end

  // ---------------------------------------------------------------------------
  // Effective per-digit blanking
  // ---------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] eff_blank;

`ifdef LZ_SUPPRESS_EN
  // lz_chain[k] is 1 when digit k and every digit above it are zero with no
  // decimal point lit, i.e. digit k is still a leading zero. Digit 0 is
  // excluded so an all-zero frame still shows a single "0".
  logic [NUM_DIGITS:1] lz_chain;

  assign lz_chain[NUM_DIGITS] = 1'b1;

  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    assign lz_chain[gi] = lz_chain[gi+1] & (act_dig_w[gi] == 4'd0) & ~act_dp_q[gi];
  end

  assign eff_blank = act_blank_q | {lz_chain[NUM_DIGITS-1:1], 1'b0};
`else
  assign eff_blank = act_blank_q;
`endif

  // ---------------------------------------------------------------------------
  // Output decode for the current slot
  // ---------------------------------------------------------------------------
  logic       in_dead;
  logic       cur_dark;
  logic [3:0] cur_digit;
  logic       cur_dp;
  logic [6:0] glyph_seg;

  always_comb begin
    in_dead   = (cnt_q < CNT_DEAD);
    cur_digit = act_dig_w[idx_q];
    cur_dp    = act_dp_q[idx_q];
    // Dark covers both the dead-time gap and a blanked/suppressed digit.
    cur_dark  = in_dead | eff_blank[idx_q];
  end

  hex_glyph u_hex_glyph (
    .value_i (cur_digit),
    .blank_i (cur_dark),
    .seg_o   (glyph_seg)
  );

  // A blanked digit keeps its anode driven (dark but on schedule); only the
  // dead-time gap releases every anode.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_d[gi] = ~(!in_dead && (idx_q == IDX_W'(gi)));
  end

  always_comb begin
    seg_d         = glyph_seg;
    dp_d          = cur_dark ? 1'b1 : ~cur_dp;
    frame_start_d = (cnt_q == '0) && (idx_q == '0);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_dig_q    <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      act_dig_q     <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_dig_q    <= pend_dig_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      act_dig_q     <= act_dig_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Scoreboard bench for seg_scan_driver (NUM_DIGITS=4, SCAN_DIV=8, DEADTIME=2).
// The driver runs a reference model based on elapsed cycles since reset and
// pushes the expected output of every cycle into a queue; a monitor pops and
// compares one entry per clock.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 8;
  localparam int DT    = 2;
  localparam int FRAME = ND * SD;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   digits = '0;
  logic [3:0]    dp_in = '0;
  logic [3:0]    blank = '0;
  logic          load = 1'b0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_start;

  always #5 clk = ~clk;

  seg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .DEADTIME   (DT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .dp_in       (dp_in),
    .blank       (blank),
    .load        (load),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: cycles elapsed since reset, plus the two frames.
  int          t = 0;
  logic [15:0] pend_dig = '0, act_dig = '0;
  logic [3:0]  pend_dp  = '0, act_dp  = '0;
  logic [3:0]  pend_bl  = '1, act_bl  = '1;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] tbl [16];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tbl[v];
  endfunction

  function automatic bit suppressed(input int k);
`ifdef LZ_SUPPRESS_EN
    if (k == 0) return 1'b0;
    for (int j = ND - 1; j >= k; j--) begin
      if (act_dig[j*4 +: 4] != 4'd0 || act_dp[j]) return 1'b0;
    end
    return 1'b1;
`else
    return (k < 0);
`endif
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    int   cnt, slot;
    cnt  = t % SD;
    slot = (t / SD) % ND;
    e.fs  = ((t % FRAME) == 0);
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    if (cnt >= DT) begin
      e.an[slot] = 1'b0;
      if (!act_bl[slot] && !suppressed(slot)) begin
        e.seg = glyph(act_dig[slot*4 +: 4]);
        e.dp  = ~act_dp[slot];
      end
    end
    return e;
  endfunction

  // One clock of stimulus; the expected output after the coming edge is queued.
  task automatic step(input logic r, input logic ld, input logic [15:0] d,
                      input logic [3:0] p, input logic [3:0] b);
    exp_t e;
    @(negedge clk);
    rst    = r;
    load   = ld;
    digits = d;
    dp_in  = p;
    blank  = b;
    if (r) begin
      e = '{an: 4'b1111, seg: 7'b1111111, dp: 1'b1, fs: 1'b0};
      exp_q.push_back(e);
      t = 0;
      pend_dig = '0; act_dig = '0;
      pend_dp  = '0; act_dp  = '0;
      pend_bl  = '1; act_bl  = '1;
      $display("t=%0t reset", $time);
    end else begin
      exp_q.push_back(model_out());
      if ((t % FRAME) == FRAME - 1) begin
        act_dig = pend_dig;
        act_dp  = pend_dp;
        act_bl  = pend_bl;
      end
      if (ld) begin
        pend_dig = d;
        pend_dp  = p;
        pend_bl  = b;
        $display("t=%0t load digits=%h dp_in=%b blank=%b", $time, d, p, b);
      end
      t++;
    end
  endtask

  // Idle cycles: inputs wander but load stays low, so nothing is captured.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    step(1'b0, 1'b1, d, p, b);
  endtask

  // Idle until the model's frame position equals pos (always within one frame).
  task automatic idle_until(input int pos);
    for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) begin
      idle(1);
    end
  endtask

  // Monitor: every clock the DUT presents one output word.
  exp_t got_e, want_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      want_e = exp_q.pop_front();
      got_e  = '{an: an, seg: seg, dp: dp, fs: frame_start};
      checks++;
      if (got_e !== want_e) begin
        failures++;
        $display("FAIL outputs @%0t: got an=%b seg=%b dp=%b fs=%b, expected an=%b seg=%b dp=%b fs=%b",
                 $time, got_e.an, got_e.seg, got_e.dp, got_e.fs,
                 want_e.an, want_e.seg, want_e.dp, want_e.fs);
      end
    end
  end

  initial begin
    // Reset, then idle with the all-blank reset frame.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, '0);
    idle(40);

    // Basic frame: 12AF with the decimal point on digit 2.
    do_load(16'h12AF, 4'b0100, 4'b0000);
    idle(80);

    // Back-to-back loads inside one frame: only the last survives.
    idle_until(5);
    do_load(16'h1111, 4'b0000, 4'b0000);
    idle(3);
    do_load(16'h2222, 4'b0000, 4'b0000);
    idle(70);

    // Load on the boundary edge itself: shows one frame later.
    idle_until(FRAME - 1);
    do_load(16'h3C5E, 4'b1001, 4'b0010);
    idle(70);

    // Reset during the lit part of slot 2.
    idle_until(2 * SD + 4);
    step(1'b1, 1'b0, '0, '0, '0);
    idle(40);

    // Leading-zero cases (plain zeros in the default build).
    do_load(16'h0040, 4'b0000, 4'b0000);
    idle(70);
    do_load(16'h0000, 4'b0000, 4'b0000);
    idle(70);
    do_load(16'h0305, 4'b0100, 4'b0000);
    idle(70);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        step(1'b1, 1'b0, '0, '0, '0);
      end else if ($urandom_range(0, 5) == 0) begin
        do_load(($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)),
                4'($urandom), 4'($urandom) & 4'($urandom));
      end else begin
        idle(1);
      end
    end

    // Let the monitor drain the last queued expectation.
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
